fp_norm_lzc: RTL and testbench
==============================

# fp_norm_lzc

Pipelined post-add normalizer for the FP32 datapath. Sits directly downstream of the adder's mantissa result. Counts leading zeros of a 32-bit mantissa using nibble-local counters combined by a boundary nibble encoder. Left-shifts the mantissa to put the leading one at bit 31, adjusts the exponent, and flags zero and denormal results, under a valid/ready handshake.

## Interface
- Parameters: none (width fixed at 32-bit mantissa, 8-bit exponent).
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream data valid.
- o_ready  out  1  block can accept upstream data this cycle.
- i_sign  in  1  sign, passed through.
- i_exp  in  8  biased exponent of i_mant.
- i_mant  in  32  unnormalized mantissa.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_sign  out  1  sign.
- o_exp  out  8  adjusted exponent.
- o_mant  out  32  normalized mantissa.
- o_lzc  out  6  leading-zero count of i_mant, 0..32.
- o_zero  out  1  i_mant was all zero.
- o_denorm  out  1  full normalization would underflow; result is denormal.

## Operation
- Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready.
- LZC uses eight nibble counters. Each gives a 2-bit local count and an all-zero flag.
- The flags feed the boundary nibble encoder: 3-bit nibble index plus all-zero Q.
- lzc = {index, local count of the selected nibble}; lzc = 32 when Q = 1.
- If Q = 1: o_zero = 1, o_mant = 0, o_exp = 0, o_denorm = 0.
- Else if i_exp > lzc: shift = lzc, o_exp = i_exp - lzc, o_denorm = 0.
- Else (i_exp <= lzc, nonzero): shift = (i_exp == 0) ? 0 : i_exp - 1; o_exp = 0; o_denorm = 1.
- o_mant = i_mant << shift, zero-filled. o_lzc always reports the true lzc, regardless of clamping.
- Exponent arithmetic is unsigned 8-bit; the compare guarantees the subtraction never wraps.
- Sign passes through unchanged.
- Each pipeline stage holds a valid bit. A stage loads when it is empty or when its successor is loading/draining.
- o_ready = !last_valid | i_ready (two-stage: !s1_valid | s2_advance).
- Stalled outputs (o_valid & !i_ready) hold all output fields stable.

## Timing
- Reset (async assert, sync deassert expected): all valid bits 0, all output registers 0. o_ready = 1 one cycle after release.
- Latency: 2 cycles with the macro defined, 1 without. Either way, throughput is 1 result/cycle when i_ready stays high.
- Stage 1 (macro defined): register lzc, Q, and inputs. Stage 2: shift, exponent adjust, output register.
- Simultaneous in/out transfer on a full pipe is accepted with no bubble.
- Reset mid-operation discards all in-flight data. No partial result appears.
- i_ready low for N cycles: at most 2 (or 1) items buffered, then o_ready = 0 until drain.

## Configuration
- FPU_NORM_PIPE2_EN defined: two-stage pipeline. LZC/encoder is registered before the shifter; latency 2.
- Not defined: LZC, encoder, shift, and exponent adjust are all combinational into one output register; latency 1. Handshake rules are identical.

## Test plan
- i_mant=0x0000_1000, i_exp=100 -> o_lzc=19, o_mant=0x8000_0000, o_exp=81, o_zero=0, o_denorm=0, after 2 cycles (1 without macro).
- i_mant=0, i_exp=50, i_sign=1 -> o_zero=1, o_lzc=32, o_mant=0, o_exp=0, o_sign=1.
- i_mant=0x0000_0F00, i_exp=5 (lzc=20) -> o_denorm=1, o_exp=0, o_mant=0x0000_F000 (shift 4), o_lzc=20.
- i_mant=0x8000_0001, i_exp=0 -> lzc=0, o_denorm=1, shift 0, o_mant=0x8000_0001, o_exp=0. Second case, i_mant=0x4000_0000, i_exp=1 -> o_denorm=1, shift 0, o_exp=0, o_mant=0x4000_0000.
- Stream 8 items with i_ready toggled 1,0,0,1...: outputs appear in order, none lost or duplicated, held stable while stalled. o_ready drops only when the pipe is full.
- Assert i_rst with 2 items in flight -> o_valid=0 immediately, all outputs 0. Next accepted input is the first result produced.

Source files
------------

// File: rtl/fp_norm_lzc.sv
// Post-add FP32 normalizer: nibble-based leading-zero count, left shift, exponent adjust.
// Define FPU_NORM_PIPE2_EN to register the LZC/encoder result before the shifter (latency 2, else 1).
module fp_norm_lzc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [31:0] i_mant,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sign,
    output logic [7:0]  o_exp,
    output logic [31:0] o_mant,
    output logic [5:0]  o_lzc,
    output logic        o_zero,
    output logic        o_denorm
);

    // Handshake: a word moves on any rising edge where valid & ready are both high;
    // the producer holds valid and data stable until that edge, and ready may depend
    // combinationally on the consumer's ready (o_ready = !last_valid | i_ready).

    logic [7:0]      nib_zero;
    logic [7:0][1:0] nib_cnt;
    logic [2:0]      nib_idx;
    logic            lzc_q;
    logic [5:0]      lzc_c;

    // Nibble k covers i_mant[31-4k -: 4]; nibble 0 is the most significant.
    always_comb begin
        nib_zero = '0;
        nib_cnt  = '0;
        for (int k = 0; k < 8; k++) begin
            casez (i_mant[31-4*k -: 4])
                4'b1???: nib_cnt[k] = 2'd0;
                4'b01??: nib_cnt[k] = 2'd1;
                4'b001?: nib_cnt[k] = 2'd2;
                default: nib_cnt[k] = 2'd3;
            endcase
            nib_zero[k] = (i_mant[31-4*k -: 4] == 4'd0);
        end
    end

    // Boundary encoder: the first non-zero nibble from the top wins.
    always_comb begin
        nib_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (!nib_zero[k]) nib_idx = k[2:0];
        end
        lzc_q = &nib_zero;
        lzc_c = lzc_q ? 6'd32 : {1'b0, nib_idx, nib_cnt[nib_idx]};
    end

    logic        x_sign;
    logic [7:0]  x_exp;
    logic [31:0] x_mant;
    logic [5:0]  x_lzc;
    logic        x_q;
    logic        x_valid;
    logic        x_load;

    assign x_load = !o_valid | i_ready;

`ifdef FPU_NORM_PIPE2_EN
    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [31:0] s1_mant;
    logic [5:0]  s1_lzc;
    logic        s1_q;

    assign o_ready = !s1_valid | x_load;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_lzc   <= '0;
            s1_q     <= 1'b0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign <= i_sign;
                s1_exp  <= i_exp;
                s1_mant <= i_mant;
                s1_lzc  <= lzc_c;
                s1_q    <= lzc_q;
            end
        end
    end

    assign x_sign  = s1_sign;
    assign x_exp   = s1_exp;
    assign x_mant  = s1_mant;
    assign x_lzc   = s1_lzc;
    assign x_q     = s1_q;
    assign x_valid = s1_valid;
`else
    assign o_ready = x_load;
    assign x_sign  = i_sign;
    assign x_exp   = i_exp;
    assign x_mant  = i_mant;
    assign x_lzc   = lzc_c;
    assign x_q     = lzc_q;
    assign x_valid = i_valid;
`endif

    logic [7:0]  lzc_ext;
    logic [7:0]  shamt;
    logic [7:0]  exp_n;
    logic        denorm_n;
    logic [31:0] mant_n;

    // When the exponent cannot absorb the full count, shift only down to exponent 1
    // and report the result as denormal with exponent 0.
    always_comb begin
        lzc_ext  = {2'b00, x_lzc};
        shamt    = 8'd0;
        exp_n    = 8'd0;
        denorm_n = 1'b0;
        mant_n   = 32'd0;
        if (!x_q) begin
            if (x_exp > lzc_ext) begin
                shamt = lzc_ext;
                exp_n = x_exp - lzc_ext;
            end else begin
                shamt    = (x_exp == 8'd0) ? 8'd0 : x_exp - 8'd1;
                denorm_n = 1'b1;
            end
            mant_n = x_mant << shamt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_sign   <= 1'b0;
            o_exp    <= '0;
            o_mant   <= '0;
            o_lzc    <= '0;
            o_zero   <= 1'b0;
            o_denorm <= 1'b0;
        end else if (x_load) begin
            o_valid <= x_valid;
            if (x_valid) begin
                o_sign   <= x_sign;
                o_exp    <= exp_n;
                o_mant   <= mant_n;
                o_lzc    <= x_lzc;
                o_zero   <= x_q;
                o_denorm <= denorm_n;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_lzc.sv
// Self-checking bench for fp_norm_lzc: directed cases, streaming with backpressure, reset.
// Expected results come from an arithmetic reference model and a scoreboard queue.
module tb_fp_norm_lzc;

`ifdef FPU_NORM_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = LAT;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [31:0] i_mant = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        o_sign;
    logic [7:0]  o_exp;
    logic [31:0] o_mant;
    logic [5:0]  o_lzc;
    logic        o_zero;
    logic        o_denorm;

    int errors = 0;
    int checks = 0;

    logic [40:0] stim_q[$];
    logic [48:0] exp_q[$];
    int          acc_q[$];

    fp_norm_lzc dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant),
        .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp),
        .o_mant(o_mant), .o_lzc(o_lzc), .o_zero(o_zero), .o_denorm(o_denorm)
    );

    always #5 i_clk = ~i_clk;

    // Reference: count zeros from bit 31 down, then apply the normalize/clamp rules.
    function automatic logic [48:0] model(input logic [40:0] s);
        logic        sg;
        logic [7:0]  e;
        logic [31:0] m;
        logic [31:0] mo;
        int lz, sh, eo;
        logic z, d;
        {sg, e, m} = s;
        lz = 0;
        while (lz < 32 && m[31-lz] == 1'b0) lz++;
        z = (m == 32'd0);
        d = 1'b0;
        eo = 0;
        sh = 0;
        if (!z) begin
            if (int'(e) > lz) begin
                sh = lz;
                eo = int'(e) - lz;
            end else begin
                d = 1'b1;
                sh = (e == 8'd0) ? 0 : int'(e) - 1;
            end
        end
        mo = z ? 32'd0 : (m << sh);
        return {sg, eo[7:0], mo, lz[5:0], z, d};
    endfunction

    function automatic logic [40:0] rand_item();
        logic [31:0] m;
        logic [7:0]  e;
        m = $urandom >> $urandom_range(0, 32);
        if ($urandom_range(0, 9) == 0) m = 32'd0;
        e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // ready_mode: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1 pattern.
    task automatic run_stream(input int ready_mode, input bit check_lat, input bit rand_valid);
        logic [40:0] cur;
        logic [48:0] got, held;
        bit offered, prev_stall;
        int cyc, occ;
        cur = '0;
        held = '0;
        offered = 0;
        prev_stall = 0;
        cyc = 0;
        while ((stim_q.size() > 0 || offered || exp_q.size() > 0) && cyc < 4000) begin
            @(negedge i_clk);
            case (ready_mode)
                0: i_ready = 1'b1;
                1: i_ready = 1'($urandom_range(0, 1));
                default: i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            if (!offered && stim_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                cur = stim_q.pop_front();
                offered = 1;
            end
            i_valid = offered;
            if (offered) {i_sign, i_exp, i_mant} = cur;
            else {i_sign, i_exp, i_mant} = {1'($urandom), 8'($urandom), $urandom};
            #1;
            got = {o_sign, o_exp, o_mant, o_lzc, o_zero, o_denorm};
            occ = exp_q.size();
            checks++;
            if (o_ready !== ((occ < DEPTH) || i_ready)) begin
                errors++;
                $display("FAIL o_ready cyc=%0d got=%b want=%b occ=%0d", cyc, o_ready, (occ < DEPTH) || i_ready, occ);
            end
            if (prev_stall) begin
                checks++;
                if (o_valid !== 1'b1 || got !== held) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b %h want v=1 %h", o_valid, got, held);
                end
            end
            if (occ == 0) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_valid got=%b want=0", o_valid);
                end
            end
            if (o_valid === 1'b1 && i_ready && occ > 0) begin
                checks++;
                if (got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL result got=%h want=%h", got, exp_q[0]);
                end
                if (check_lat) begin
                    checks++;
                    if (cyc - acc_q[0] != LAT) begin
                        errors++;
                        $display("FAIL latency got=%0d want=%0d", cyc - acc_q[0], LAT);
                    end
                end
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            prev_stall = (o_valid === 1'b1) && !i_ready;
            held = got;
            if (i_valid && o_ready) begin
                exp_q.push_back(model(cur));
                acc_q.push_back(cyc);
                offered = 0;
            end
            cyc++;
        end
        checks++;
        if (stim_q.size() != 0 || exp_q.size() != 0 || offered) begin
            errors++;
            $display("FAIL stream_timeout got pending=%0d want 0", exp_q.size() + stim_q.size());
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_valid, o_sign, o_exp, o_mant, o_lzc, o_zero, o_denorm} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {o_valid, o_sign, o_exp, o_mant, o_lzc, o_zero, o_denorm});
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", o_ready);
        end
    endtask

    task automatic test_directed();
        // {sign, exp, mant} -> {lzc, exp_out, mant_out, zero, denorm}
        logic [40:0] vin [7];
        logic [47:0] vout[7];
        vin[0] = {1'b0, 8'd100, 32'h0000_1000}; vout[0] = {6'd19, 8'd81,  32'h8000_0000, 1'b0, 1'b0};
        vin[1] = {1'b1, 8'd50,  32'h0000_0000}; vout[1] = {6'd32, 8'd0,   32'h0000_0000, 1'b1, 1'b0};
        vin[2] = {1'b0, 8'd5,   32'h0000_0F00}; vout[2] = {6'd20, 8'd0,   32'h0000_F000, 1'b0, 1'b1};
        vin[3] = {1'b0, 8'd0,   32'h8000_0001}; vout[3] = {6'd0,  8'd0,   32'h8000_0001, 1'b0, 1'b1};
        vin[4] = {1'b0, 8'd1,   32'h4000_0000}; vout[4] = {6'd1,  8'd0,   32'h4000_0000, 1'b0, 1'b1};
        vin[5] = {1'b1, 8'd21,  32'h0000_0F00}; vout[5] = {6'd20, 8'd1,   32'hF000_0000, 1'b0, 1'b0};
        vin[6] = {1'b0, 8'd255, 32'h0000_0001}; vout[6] = {6'd31, 8'd224, 32'h8000_0000, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge i_clk);
            i_ready = 1'b1;
            i_valid = 1'b1;
            {i_sign, i_exp, i_mant} = vin[i];
            @(negedge i_clk);
            i_valid = 1'b0;
            for (int w = 1; w < LAT; w++) @(negedge i_clk);
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_sign !== vin[i][40] ||
                {o_lzc, o_exp, o_mant, o_zero, o_denorm} !== vout[i]) begin
                errors++;
                $display("FAIL directed_%0d got v=%b s=%b %h want v=1 s=%b %h", i, o_valid, o_sign,
                         {o_lzc, o_exp, o_mant, o_zero, o_denorm}, vin[i][40], vout[i]);
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) stim_q.push_back(rand_item());
        run_stream(0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) stim_q.push_back(rand_item());
        run_stream(2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) stim_q.push_back(rand_item());
        run_stream(1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midflight();
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b1;
        {i_sign, i_exp, i_mant} = {1'b1, 8'd77, 32'h0001_2345};
        @(negedge i_clk);
        {i_sign, i_exp, i_mant} = {1'b0, 8'd3, 32'h0000_00F0};
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_valid got=%b want=1", o_valid);
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_sign, o_exp, o_mant, o_lzc, o_zero, o_denorm} !== '0) begin
            errors++;
            $display("FAIL midflight_reset got=%h want=0", {o_valid, o_sign, o_exp, o_mant, o_lzc, o_zero, o_denorm});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ready = 1'b1;
        exp_q.delete();
        acc_q.delete();
        stim_q.push_back({1'b0, 8'd40, 32'h0000_0003});
        stim_q.push_back(rand_item());
        run_stream(0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
